// File: rtl/iob2axi_wr_split_pkg.sv
// Shared definitions for the IOb-to-AXI burst splitters: boundary width,
// default AXI len width, FSM encoding and a small width helper.
package iob2axi_wr_split_pkg;

  localparam int unsigned BOUNDARY_W    = 12;
  localparam int unsigned AXI_LEN_W_DEF = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StIssue,
    StWait,
    StDone
  } split_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iob2axi_burst_calc.sv
// Combinational burst sizer: the largest legal burst from the current address,
// limited by words remaining, max AXI burst length and the next 4 KB boundary.
module iob2axi_burst_calc
  import iob2axi_wr_split_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AXI_LEN_W  = AXI_LEN_W_DEF,
  parameter int unsigned XFER_LEN_W = 16
) (
  input  logic [ADDR_W-1:0]     addr,
  input  logic [XFER_LEN_W-1:0] remaining,
  output logic [AXI_LEN_W:0]    beats
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFFS_W = $clog2(BYTES);
  localparam int unsigned CW     = max3(XFER_LEN_W, AXI_LEN_W + 1, BOUNDARY_W + 1);

  localparam logic [CW-1:0]         MaxBeats = CW'(1) << AXI_LEN_W;
  localparam logic [BOUNDARY_W:0]   PageSize = {1'b1, {BOUNDARY_W{1'b0}}};

  logic [BOUNDARY_W:0] room_bytes;
  logic [CW-1:0]       rem_w;
  logic [CW-1:0]       room_w;
  logic [CW-1:0]       lim;
  logic                unused_bits;

  // A page-aligned address yields a full page of headroom (4096 - 0).
  assign room_bytes = PageSize - {1'b0, addr[BOUNDARY_W-1:0]};
  assign room_w     = CW'(room_bytes >> OFFS_W);
  assign rem_w      = CW'(remaining);

  always_comb begin
    lim = rem_w;
    if (MaxBeats < lim) lim = MaxBeats;
    if (room_w < lim)   lim = room_w;
  end

  assign beats = lim[AXI_LEN_W:0];

  assign unused_bits = ^{addr[ADDR_W-1:BOUNDARY_W], lim};

endmodule

// File: rtl/iob2axi_wr_split.sv
// Splits one word-granular write request into AXI INCR bursts that respect the
// max burst length and 4 KB boundaries, issuing them to the write engine serially.
module iob2axi_wr_split
  import iob2axi_wr_split_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AXI_LEN_W  = AXI_LEN_W_DEF,
  parameter int unsigned XFER_LEN_W = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [XFER_LEN_W-1:0] req_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  run_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic [AXI_LEN_W-1:0]  length_o,
  input  logic                  eng_ready_i,
  input  logic                  eng_error_i
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFFS_W = $clog2(BYTES);

  localparam logic [AXI_LEN_W:0] OneBeat = {{AXI_LEN_W{1'b0}}, 1'b1};

  split_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [XFER_LEN_W-1:0] rem_q, rem_d;
  logic [AXI_LEN_W:0]    beats_q, beats_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic [AXI_LEN_W-1:0]  out_len_q, out_len_d;
  logic [AXI_LEN_W:0]    calc_beats;

  iob2axi_burst_calc #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .AXI_LEN_W (AXI_LEN_W),
    .XFER_LEN_W(XFER_LEN_W)
  ) u_burst_calc (
    .addr     (addr_q),
    .remaining(rem_q),
    .beats    (calc_beats)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    err_d      = err_q;
    out_addr_d = out_addr_q;
    out_len_d  = out_len_q;
    run_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          rem_d  = req_len_i;
          err_d  = 1'b0;
          if (req_addr_i[OFFS_W-1:0] != '0) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else begin
          // Burst address/length are registered here so they hold through the burst.
          beats_d    = calc_beats;
          out_addr_d = addr_q;
          out_len_d  = AXI_LEN_W'(calc_beats - OneBeat);
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (eng_ready_i) begin
          run_o   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (eng_ready_i) begin
          err_d   = err_q | eng_error_i;
          addr_d  = addr_q + (ADDR_W'(beats_q) << OFFS_W);
          rem_d   = rem_q - XFER_LEN_W'(beats_q);
          state_d = eng_error_i ? StDone : StCalc;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      err_q      <= 1'b0;
      out_addr_q <= '0;
      out_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      err_q      <= err_d;
      out_addr_q <= out_addr_d;
      out_len_q  <= out_len_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign error_o     = err_q;
  assign addr_o      = out_addr_q;
  assign length_o    = out_len_q;

endmodule

// File: tb/tb_iob2axi_wr_split.sv
// Scoreboard bench for iob2axi_wr_split with a simple write-engine model.
module tb_iob2axi_wr_split;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [15:0] req_len_i = '0;
  logic        busy_o, done_o, error_o, run_o;
  logic [31:0] addr_o;
  logic [7:0]  length_o;
  logic        eng_ready_i;
  logic        eng_error_i;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  burst_t exp_bursts[$];
  logic   exp_done[$];

  int checks = 0;
  int errors = 0;
  int run_count = 0;
  int err_target = -1;
  int cnt = 0;

  always #5 clk_i = ~clk_i;

  iob2axi_wr_split dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_len_i  (req_len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .run_o      (run_o),
    .addr_o     (addr_o),
    .length_o   (length_o),
    .eng_ready_i(eng_ready_i),
    .eng_error_i(eng_error_i)
  );

  // Engine model: ready drops after run_o, returns 5 cycles later.
  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      eng_ready_i <= 1'b1;
      cnt         <= 0;
    end else if (run_o) begin
      eng_ready_i <= 1'b0;
      cnt         <= 5;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) eng_ready_i <= 1'b1;
    end
  end

  always @(posedge clk_i) if (run_o) run_count <= run_count + 1;

  assign eng_error_i = eng_ready_i && (run_count == err_target);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every burst start and completion against the scoreboard.
  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (run_o) begin
        if (exp_bursts.size() == 0) begin
          fail_now("unexpected run_o");
        end else begin
          burst_t b;
          b = exp_bursts.pop_front();
          chk("burst addr", 64'(addr_o), 64'(b.addr));
          chk("burst len", 64'(length_o), 64'(b.len));
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected done_o");
        end else begin
          logic e;
          e = exp_done.pop_front();
          chk("done error", 64'(error_o), 64'(e));
        end
      end
    end
  end

  task automatic push_burst(input logic [31:0] a, input logic [7:0] l);
    burst_t b;
    b.addr = a;
    b.len  = l;
    exp_bursts.push_back(b);
  endtask

  task automatic accept(input logic [31:0] a, input logic [15:0] l);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) fail_now("timeout waiting req_ready_o");
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_len_i   = l;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk_i);
    while (!done_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) fail_now("timeout waiting done_o");
    @(negedge clk_i);
    chk("done one cycle", 64'(done_o), 64'(0));
  endtask

  task automatic chk_reset_outputs();
    chk("rst req_ready", 64'(req_ready_o), 64'(1));
    chk("rst busy", 64'(busy_o), 64'(0));
    chk("rst done", 64'(done_o), 64'(0));
    chk("rst error", 64'(error_o), 64'(0));
    chk("rst run", 64'(run_o), 64'(0));
    chk("rst addr_o", 64'(addr_o), 64'(0));
    chk("rst length_o", 64'(length_o), 64'(0));
  endtask

  initial begin
    int n;
    #1 chk_reset_outputs();
    #22 arst_n_i = 1'b1;

    // 1: single aligned burst
    push_burst(32'h1000, 8'd15);
    exp_done.push_back(1'b0);
    accept(32'h1000, 16'd16);
    wait_done();

    // 2: split by max burst length
    push_burst(32'h000, 8'd255);
    push_burst(32'h400, 8'd255);
    push_burst(32'h800, 8'd87);
    exp_done.push_back(1'b0);
    accept(32'h0, 16'd600);
    wait_done();

    // 3: split at 4 KB boundary
    push_burst(32'h0FF0, 8'd3);
    push_burst(32'h1000, 8'd3);
    exp_done.push_back(1'b0);
    accept(32'h0FF0, 16'd8);
    wait_done();

    // 4a: zero length, done in cycle 2
    exp_done.push_back(1'b0);
    accept(32'h2000, 16'd0);
    @(negedge clk_i);
    chk("zero len cycle1 done", 64'(done_o), 64'(0));
    @(negedge clk_i);
    chk("zero len cycle2 done", 64'(done_o), 64'(1));
    @(negedge clk_i);

    // 4b: misaligned address
    exp_done.push_back(1'b1);
    accept(32'h1002, 16'd4);
    wait_done();
    chk("misaligned error held", 64'(error_o), 64'(1));

    // 5: engine error on first completion aborts the rest
    err_target = run_count + 1;
    push_burst(32'h0, 8'd255);
    exp_done.push_back(1'b1);
    accept(32'h0, 16'd600);
    wait_done();
    err_target = -1;
    push_burst(32'h2000, 8'd3);
    exp_done.push_back(1'b0);
    accept(32'h2000, 16'd4);
    @(negedge clk_i);
    chk("error cleared on accept", 64'(error_o), 64'(0));
    wait_done();

    // 6: reset during WAIT of burst 2
    n = run_count;
    push_burst(32'h000, 8'd255);
    push_burst(32'h400, 8'd255);
    accept(32'h0, 16'd600);
    begin
      int k;
      k = 0;
      while (run_count != n + 2 && k < 5000) begin
        @(negedge clk_i);
        k++;
      end
      if (run_count != n + 2) fail_now("timeout waiting burst 2");
    end
    repeat (2) @(negedge clk_i);
    chk("busy before reset", 64'(busy_o), 64'(1));
    #2 arst_n_i = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk_i);
    arst_n_i = 1'b1;
    push_burst(32'h3000, 8'd3);
    exp_done.push_back(1'b0);
    accept(32'h3000, 16'd4);
    wait_done();

    repeat (3) @(negedge clk_i);
    chk("bursts left", 64'(exp_bursts.size()), 64'(0));
    chk("dones left", 64'(exp_done.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob2axi_wr_split.md
Name: iob2axi_wr_split

Overview:
Burst splitter that sits directly upstream of the AXI write engine and drives that engine's run/addr/length control interface.
It accepts one arbitrary-length word write request and cuts it into AXI INCR bursts. Each burst is at most 2^AXI_LEN_W beats and never crosses a 4 KB boundary.
It issues the bursts to the engine one at a time, ORs their error results together, and signals completion once.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width in bits; bytes per beat BYTES = DATA_W/8 (power of 2)
AXI_LEN_W, 8, AXI len width; max burst = 2^AXI_LEN_W beats
XFER_LEN_W, 16, request length width in words

Ports:
clk_i  in  1  clock
arst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request strobe
req_ready_o  out  1  high only in IDLE; request accepted when req_valid_i & req_ready_o
req_addr_i  in  ADDR_W  start byte address
req_len_i  in  XFER_LEN_W  number of words (0 allowed)
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle completion pulse
error_o  out  1  result of the last request; valid from done_o until the next acceptance
run_o  out  1  one-cycle burst start pulse to the engine
addr_o  out  ADDR_W  burst byte address; stable from run_o until the burst completes
length_o  out  AXI_LEN_W  burst beats minus 1
eng_ready_i  in  1  engine idle/ready; registered in the engine, drops the cycle after run_o
eng_error_i  in  1  engine error; valid while eng_ready_i is high

Behaviour:
- Clock and reset: single clock clk_i. arst_n_i is asynchronous and active-low.
- Reset values: state=IDLE, req_ready_o=1, busy_o=0, done_o=0, error_o=0, run_o=0, addr_o=0, length_o=0. Internal addr/remaining/beats registers clear to 0.
- FSM states: IDLE, CALC, ISSUE, WAIT, DONE.
- IDLE: on acceptance, latch addr and remaining=req_len_i, clear error_o, go to CALC.
  - If any of addr[log2(BYTES)-1:0] is nonzero, set error_o=1 and go straight to DONE; no run_o is issued.
- CALC:
  - If remaining==0, go to DONE.
  - Otherwise register beats = min(remaining, 2^AXI_LEN_W, (4096 - addr[11:0]) >> log2(BYTES)), then go to ISSUE.
  - beats is AXI_LEN_W+1 bits wide and is always >= 1.
- ISSUE: wait for eng_ready_i=1. In that cycle drive run_o=1, addr_o=addr and length_o=beats-1, then go to WAIT. run_o is never asserted in any other state.
- WAIT:
  - The cycle after run_o, eng_ready_i is 0.
  - Stay in WAIT until eng_ready_i=1. In that cycle: error_o |= eng_error_i, addr += beats*BYTES (mod 2^ADDR_W), remaining -= beats.
  - If eng_error_i=1, go to DONE and abort the remaining bursts. Otherwise go to CALC.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Acceptance at cycle 0 → CALC in cycle 1 → earliest run_o in cycle 2.
  - Inter-burst gap is 2 cycles after the engine becomes ready (WAIT→CALC→ISSUE).
  - Zero-length request: done_o in cycle 2.
- Concurrency: req_valid_i is ignored while busy (req_ready_o=0). Only one burst is outstanding at a time.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values. The engine is reset by the same reset.
- Address arithmetic: 4 KB boundary math uses addr[11:0] only, so a 4 KB-aligned address gives 4096/BYTES beats of headroom. Wrap above 2^ADDR_W is modular and unchecked.

Decomposition:
- Shared package/header: AXI_LEN_W, BOUNDARY_W=12 (4 KB), the state encodings, and the BYTES/log2(BYTES) localparams. AXI macros are shared with the write engine.
- One natural sub-module: iob2axi_burst_calc. It is purely combinational: inputs addr, remaining; output beats (min of the three limits). It is reused by the read-side splitter.

Test Plan:
(DATA_W=32, BYTES=4; the engine model raises eng_ready_i 5 cycles after run_o unless stated.)
1. addr=0x1000, len=16 → one run_o with addr_o=0x1000, length_o=15; done_o one cycle; error_o=0.
2. addr=0x0000, len=600 → three run_o: (0x000,255), (0x400,255), (0x800,87); single done_o; error_o=0.
3. addr=0x0FF0, len=8 → run_o (0x0FF0,3) then (0x1000,3); no burst crosses 0x1000.
4. len=0 → done_o in cycle 2 after acceptance; no run_o; error_o=0. addr=0x1002, len=4 → done_o, error_o=1, no run_o.
5. addr=0, len=600, eng_error_i=1 on the first completion → exactly one run_o; done_o with error_o=1; next request clears error_o.
6. Deassert arst_n_i while in WAIT of burst 2 → all outputs at reset values immediately; req_ready_o=1 after release; a new len=4 request completes normally.
